frame_config_ctrl: RTL
======================

Name: frame_config_ctrl

Overview:
- Fabric configuration sequencer. Parses a 32-bit bitstream word stream and assembles full-column frames.
- Drives FrameData and a one-cycle one-hot FrameStrobe into the per-tile config latches that program the switch matrices and BELs.
- Sits between the external config port (UART/SelectMAP front end) and the fabric's frame distribution network.

Parameters:
- NUM_ROWS, 16, tile rows per column; one 32-bit data word per row per frame.
- NUM_COLUMNS, 10, fabric columns addressable.
- FRAMES_PER_COL, 20, frames per column.
- SYNC_WORD, 32'hFAB0_FAB1, stream synchronisation pattern.

Ports:
- CLK  in  1  configuration clock.
- resetn  in  1  asynchronous active-low reset.
- s_data  in  32  bitstream word.
- s_valid  in  1  word valid.
- s_ready  out  1  word accepted when s_valid && s_ready.
- FrameData  out  NUM_ROWS*32  assembled frame; word k occupies [k*32 +: 32].
- FrameStrobe  out  NUM_COLUMNS*FRAMES_PER_COL  one-hot write strobe; bit index = column*FRAMES_PER_COL + frame.
- busy  out  1  high in any state other than HUNT.
- error  out  1  sticky; cleared only by reset.
- frames_written  out  16  count of strobes issued, saturating at 16'hFFFF.

Behaviour:
- Reset (async, resetn low): state=HUNT; all outputs 0 except s_ready=1. Reset asserted mid-frame drops FrameStrobe immediately and discards partial frame data.
- States: HUNT, HDR, DATA, STROBE.
- HUNT: accepts and discards words until s_data==SYNC_WORD, then goes to HDR.
- HDR: descriptor word. [31:24] cmd, [23:16] column, [15:8] frame, [7:0] ignored.
  - cmd 8'h01 = write frame: latch column/frame, clear word counter, go to DATA.
  - cmd 8'h02 = desync: go to HUNT.
  - s_data==SYNC_WORD in HDR: stay in HDR (resync, no error).
  - Any other cmd: set error, stay in HDR.
- Address check: column>=NUM_COLUMNS or frame>=FRAMES_PER_COL sets error. DATA still consumes exactly NUM_ROWS words, STROBE is skipped, and the block returns to HDR.
- DATA: each accepted word is written to FrameData slot k (k=0..NUM_ROWS-1). SYNC_WORD value is treated as plain data here. After the NUM_ROWS-th word: go to STROBE if the address is valid, else to HDR.
- STROBE: exactly one cycle, with s_ready=0. The single FrameStrobe bit is high, FrameData is stable, and frames_written increments. Next state HDR.
- FrameData is registered and held from the STROBE cycle until the first data word of the next frame is accepted.
- s_ready=1 in HUNT, HDR and DATA; 0 only in STROBE. The upstream may hold s_valid high across STROBE; the word is taken the following cycle.
- Throughput: 1 sync word, then per frame 1 header + NUM_ROWS data + 1 strobe cycle.
- Gaps in s_valid are allowed anywhere; state and counters hold.
- FrameStrobe is never multi-hot and is never asserted outside STROBE.

Optional Feature:
- Macro: FRAME_CRC_EN.
- Defined:
  - After the NUM_ROWS data words, DATA accepts one extra word: the XOR of all data words in the frame.
  - Match: go to STROBE.
  - Mismatch: set error, skip STROBE, return to HDR.
  - Checksum word is consumed even when the address is invalid.
- Undefined: no checksum word; the behaviour above applies unchanged.

Test Plan:
- Basic write: SYNC, 32'h01_03_05_00, 16 words 32'h1000_0000+k → one-cycle FrameStrobe[65]=1; FrameData[k*32+:32]=32'h1000_0000+k; frames_written=1; error=0.
- Back-to-back frames: SYNC, header col0/frame0 + 16 words, header col9/frame19 + 16 words, s_valid held high throughout → strobes on bit 0 then bit 199; s_ready low exactly in the 2 strobe cycles; no word lost.
- Bad address: header 32'h01_0A_00_00 + 16 words → error=1; no FrameStrobe; next header col1/frame2 still produces FrameStrobe[22].
- Desync/hunt: random words, SYNC, 32'h02_00_00_00, then 32'h01_00_00_00 + 16 words → no strobe, because the block is back in HUNT; busy=0.
- Reset mid-frame: after 8 data words, pulse resetn low for 1 cycle → outputs zero; a following full SYNC/header/frame produces a correct strobe with new data only.
- With FRAME_CRC_EN: frame words 1..16 plus checksum 32'h0000_0010 → strobe; same frame with checksum 32'h0 → error=1, no strobe.

Source files
------------

// File: rtl/frame_config_ctrl.sv
// rtl/frame_config_ctrl.sv - fabric config sequencer: sync hunt, frame header decode, frame assembly and one-hot strobe (optional FRAME_CRC_EN checksum word)
module frame_config_ctrl #(
    parameter int unsigned NUM_ROWS       = 16,
    parameter int unsigned NUM_COLUMNS    = 10,
    parameter int unsigned FRAMES_PER_COL = 20,
    parameter logic [31:0] SYNC_WORD      = 32'hFAB0_FAB1
) (
    input  logic                                  CLK,
    input  logic                                  resetn,
    input  logic [31:0]                           s_data,
    input  logic                                  s_valid,
    output logic                                  s_ready,
    output logic [NUM_ROWS*32-1:0]                FrameData,
    output logic [NUM_COLUMNS*FRAMES_PER_COL-1:0] FrameStrobe,
    output logic                                  busy,
    output logic                                  error,
    output logic [15:0]                           frames_written
);

    localparam int unsigned NUM_STROBES = NUM_COLUMNS * FRAMES_PER_COL;
    localparam int unsigned IDX_W       = $clog2(NUM_STROBES);
    localparam int unsigned CNT_W       = $clog2(NUM_ROWS + 1);

    typedef enum logic [1:0] {HUNT, HDR, DATA, STROBE} state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      word_cnt_q;
    logic                  addr_ok_q;
    logic [IDX_W-1:0]      strobe_idx_q;
    logic                  error_q;
    logic                  err_set;
    logic [15:0]           frames_q;
    logic [NUM_ROWS*32-1:0] frame_data_q;
    logic                  accept;
    logic                  is_sync;
    logic [7:0]            hdr_cmd, hdr_col, hdr_frm;
    logic                  hdr_addr_ok;
    logic                  last_word;
`ifdef FRAME_CRC_EN
    logic [31:0]           crc_q;
    logic                  crc_phase;
`endif

    assign accept      = s_valid && s_ready;
    assign is_sync     = (s_data == SYNC_WORD);
    assign hdr_cmd     = s_data[31:24];
    assign hdr_col     = s_data[23:16];
    assign hdr_frm     = s_data[15:8];
    assign hdr_addr_ok = (32'(hdr_col) < NUM_COLUMNS) && (32'(hdr_frm) < FRAMES_PER_COL);
    assign last_word   = (word_cnt_q == CNT_W'(NUM_ROWS - 1));
`ifdef FRAME_CRC_EN
    assign crc_phase   = (word_cnt_q == CNT_W'(NUM_ROWS));
`endif

    assign s_ready        = (state_q != STROBE);
    assign busy           = (state_q != HUNT);
    assign error          = error_q;
    assign frames_written = frames_q;
    assign FrameData      = frame_data_q;

    // State register
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) state_q <= HUNT;
        else         state_q <= state_d;
    end

    // Next-state decode and error detection
    always_comb begin
        state_d = state_q;
        err_set = 1'b0;
        case (state_q)
            HUNT: begin
                if (accept && is_sync) state_d = HDR;
            end
            HDR: begin
                if (accept && !is_sync) begin
                    if (hdr_cmd == 8'h01) begin
                        state_d = DATA;
                        if (!hdr_addr_ok) err_set = 1'b1;
                    end else if (hdr_cmd == 8'h02) begin
                        state_d = HUNT;
                    end else begin
                        err_set = 1'b1;
                    end
                end
            end
            DATA: begin
`ifdef FRAME_CRC_EN
                if (accept && crc_phase) begin
                    if (s_data != crc_q)  err_set = 1'b1;
                    state_d = ((s_data == crc_q) && addr_ok_q) ? STROBE : HDR;
                end
`else
                if (accept && last_word) state_d = addr_ok_q ? STROBE : HDR;
`endif
            end
            STROBE:  state_d = HDR;
            default: state_d = HUNT;
        endcase
    end

    // One-hot strobe decoded from the address latched at header time
    always_comb begin
        FrameStrobe = '0;
        if (state_q == STROBE) FrameStrobe[strobe_idx_q] = 1'b1;
    end

    // Header latch, frame assembly, sticky error and strobe counter
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            word_cnt_q   <= '0;
            addr_ok_q    <= 1'b0;
            strobe_idx_q <= '0;
            error_q      <= 1'b0;
            frames_q     <= '0;
            frame_data_q <= '0;
`ifdef FRAME_CRC_EN
            crc_q        <= '0;
`endif
        end else begin
            if (err_set) error_q <= 1'b1;
            if (state_q == HDR && state_d == DATA) begin
                word_cnt_q   <= '0;
                addr_ok_q    <= hdr_addr_ok;
                strobe_idx_q <= IDX_W'(32'(hdr_col) * FRAMES_PER_COL + 32'(hdr_frm));
`ifdef FRAME_CRC_EN
                crc_q        <= '0;
`endif
            end
            if (state_q == DATA && accept && word_cnt_q < CNT_W'(NUM_ROWS)) begin
                for (int k = 0; k < int'(NUM_ROWS); k++) begin
                    if (word_cnt_q == CNT_W'(k)) frame_data_q[k*32 +: 32] <= s_data;
                end
                word_cnt_q <= word_cnt_q + CNT_W'(1);
`ifdef FRAME_CRC_EN
                crc_q      <= crc_q ^ s_data;
`endif
            end
            if (state_q == STROBE && frames_q != 16'hFFFF) frames_q <= frames_q + 16'd1;
        end
    end

endmodule
